stream_dispatcher: RTL and testbench

Parametrised, double-buffered successor to the BitWave dispatcher. Stores activation and weight lines in two ping-pong banks. Streams a committed bank to the PE array over a valid/ready handshake, applying the four BitWave broadcast-sharing modes independently to activations and weights. The host fills one bank while the other bank streams.

---
 rtl/stream_dispatcher_pkg.sv | 24 ++
 rtl/stream_dispatcher_if.sv | 29 ++
 rtl/stream_dispatcher_expand.sv | 39 +++
 rtl/stream_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_stream_dispatcher.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_dispatcher_pkg.sv
// disp_pkg: shared types and constants for the stream dispatcher slice.
// Holds the broadcast-sharing mode enum, the streaming FSM state enum and
// the group geometry used by the line expander.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_INTRA = 2'b01,
    MODE_INTER = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Output line is always 16 groups wide.
  localparam int NGROUP    = 16;
  // Replication factor of one group in the intra-sharing mode.
  localparam int INTRA_REP = 4;

endpackage

// File: rtl/stream_dispatcher_if.sv
// stream_dispatcher_if: output stream from the dispatcher to the PE array.
// master = dispatcher side (drives beats), slave = PE array side (drives ready).
interface stream_dispatcher_if #(
  parameter int DATA_W = 1024
) ();

  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DATA_W-1:0] activations;
  logic [DATA_W-1:0] weight_columns;

  modport master (
    output out_valid,
    output out_last,
    output activations,
    output weight_columns,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_last,
    input  activations,
    input  weight_columns,
    output out_ready
  );

endinterface

// File: rtl/stream_dispatcher_expand.sv
// disp_expand: purely combinational broadcast-sharing expander.
// Every output group picks one source group of the input line according to
// the mode: pass-through, per-group 4x replication, low-quarter 4x
// replication, or group 0 broadcast to all 16 positions.
module disp_expand
  import disp_pkg::*;
#(
  parameter int GROUP_W = 64
) (
  input  logic [NGROUP*GROUP_W-1:0] line_in,
  input  mode_t                     mode,
  output logic [NGROUP*GROUP_W-1:0] line_out
);

  genvar gi;
  for (gi = 0; gi < NGROUP; gi++) begin : g_group
    // Source group indices are fixed per output position, so the mux is a
    // 4:1 select over constant slices.
    localparam int SRC_INTRA = gi / INTRA_REP;
    localparam int SRC_INTER = gi % INTRA_REP;

    logic [GROUP_W-1:0] grp;

    // Select the source group for this output position.
    always_comb begin
      grp = line_in[gi*GROUP_W +: GROUP_W];
      case (mode)
        MODE_NONE:  grp = line_in[gi*GROUP_W +: GROUP_W];
        MODE_INTRA: grp = line_in[SRC_INTRA*GROUP_W +: GROUP_W];
        MODE_INTER: grp = line_in[SRC_INTER*GROUP_W +: GROUP_W];
        MODE_BOTH:  grp = line_in[GROUP_W-1:0];
        default:    grp = line_in[gi*GROUP_W +: GROUP_W];
      endcase
    end

    assign line_out[gi*GROUP_W +: GROUP_W] = grp;
  end

endmodule

// File: rtl/stream_dispatcher.sv
// stream_dispatcher: double-buffered activation/weight line store that
// streams a committed bank to the PE array with independent broadcast
// sharing for activations and weights. The host fills one bank while the
// other streams.
// Optional feature: define STREAM_DISPATCHER_STALL_CNT_EN to add the
// stall_cnt port (saturating count of stalled output cycles).
module stream_dispatcher
  import disp_pkg::*;
#(
  parameter int DATA_W  = 1024,
  parameter int GROUP_W = 64,
  parameter int DEPTH   = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   w_in,
  input  logic [DATA_W-1:0]   a_in,
  input  logic                wr_commit,
  output logic                fill_ready,
  input  logic                start,
  input  logic [AW:0]         len,
  input  logic [1:0]          a_mode,
  input  logic [1:0]          w_mode,
  output logic                start_err,
  output logic                busy,
  stream_dispatcher_if.master strm,
  output logic                done
`ifdef STREAM_DISPATCHER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] a_mem [2*DEPTH];
  logic [DATA_W-1:0] w_mem [2*DEPTH];

  state_t            state_reg, state_next;
  logic [1:0]        full_reg, full_next;
  logic              fill_ptr_reg, drain_ptr_reg;
  mode_t             a_mode_reg, w_mode_reg;
  logic [AW:0]       eff_len_reg, rd_ptr_reg;
  logic              out_valid_reg, out_last_reg, start_err_reg;
  logic [DATA_W-1:0] act_reg, wgt_reg;
  logic [DATA_W-1:0] a_rd, w_rd, a_exp, w_exp;
  logic              wr_ok, commit_ok, start_ok, release_bank, handshake, load;

  assign fill_ready   = !full_reg[fill_ptr_reg];
  assign wr_ok        = wr_en && fill_ready;
  assign commit_ok    = wr_commit && fill_ready;
  assign start_ok     = (state_reg == IDLE) && start && full_reg[drain_ptr_reg];
  assign release_bank = (state_reg == DONE);
  assign handshake    = out_valid_reg && strm.out_ready;
  // A new beat is fetched whenever lines remain and the output slot is free
  // or being emptied this cycle.
  assign load = (state_reg == STREAM) && (rd_ptr_reg < eff_len_reg) &&
                (!out_valid_reg || strm.out_ready);

  // Host writes land in the current fill bank only while it is free.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      a_mem[{fill_ptr_reg, wr_addr}] <= a_in;
      w_mem[{fill_ptr_reg, wr_addr}] <= w_in;
    end
  end

  assign a_rd = a_mem[{drain_ptr_reg, rd_ptr_reg[AW-1:0]}];
  assign w_rd = w_mem[{drain_ptr_reg, rd_ptr_reg[AW-1:0]}];

  disp_expand #(.GROUP_W(GROUP_W)) u_expand_a (
    .line_in  (a_rd),
    .mode     (a_mode_reg),
    .line_out (a_exp)
  );

  disp_expand #(.GROUP_W(GROUP_W)) u_expand_w (
    .line_in  (w_rd),
    .mode     (w_mode_reg),
    .line_out (w_exp)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: leave STREAM on the last handshake, or at once when
  // there is nothing to stream.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = STREAM;
      STREAM:  if ((eff_len_reg == '0) || (handshake && out_last_reg)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank occupancy: a commit and a release always target different banks,
  // so both can apply in the same cycle.
  always_comb begin
    full_next = full_reg;
    if (commit_ok)    full_next[fill_ptr_reg]  = 1'b1;
    if (release_bank) full_next[drain_ptr_reg] = 1'b0;
  end

  // Bank flags and ping-pong pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_reg      <= 2'b00;
      fill_ptr_reg  <= 1'b0;
      drain_ptr_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (commit_ok)    fill_ptr_reg  <= ~fill_ptr_reg;
      if (release_bank) drain_ptr_reg <= ~drain_ptr_reg;
    end
  end

  // Stream datapath: latch the request, then fetch/expand/present beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_mode_reg    <= MODE_NONE;
      w_mode_reg    <= MODE_NONE;
      eff_len_reg   <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      act_reg       <= '0;
      wgt_reg       <= '0;
      start_err_reg <= 1'b0;
    end else begin
      start_err_reg <= (state_reg == IDLE) && start && !full_reg[drain_ptr_reg];
      if (start_ok) begin
        a_mode_reg  <= mode_t'(a_mode);
        w_mode_reg  <= mode_t'(w_mode);
        eff_len_reg <= (len > DEPTH_L) ? DEPTH_L : len;
        rd_ptr_reg  <= '0;
      end
      if (load) begin
        act_reg       <= a_exp;
        wgt_reg       <= w_exp;
        out_valid_reg <= 1'b1;
        out_last_reg  <= (rd_ptr_reg == eff_len_reg - ONE_L);
        rd_ptr_reg    <= rd_ptr_reg + ONE_L;
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

`ifdef STREAM_DISPATCHER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of cycles where a beat waits on the PE array.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                        stall_cnt_reg <= '0;
    else if (start_ok)                                                stall_cnt_reg <= '0;
    else if (out_valid_reg && !strm.out_ready && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

  assign strm.out_valid      = out_valid_reg;
  assign strm.out_last       = out_last_reg;
  assign strm.activations    = act_reg;
  assign strm.weight_columns = wgt_reg;
  assign start_err           = start_err_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = (state_reg == DONE);

endmodule

// File: tb/tb_stream_dispatcher.sv
// tb_stream_dispatcher: table-driven stream transactions plus hand-written
// ping-pong, backpressure and mid-stream reset sequences. Expected beats are
// queued when a stream is started and checked as the PE side accepts them.
module tb_stream_dispatcher;

  localparam int DATA_W  = 1024;
  localparam int GROUP_W = 64;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;

  typedef logic [DATA_W-1:0] line_t;
  typedef struct packed {
    logic [DEPTH-1:0][DATA_W-1:0] a;
    logic [DEPTH-1:0][DATA_W-1:0] w;
  } bank_t;
  typedef struct packed {
    line_t act;
    line_t wgt;
    logic  last;
  } beat_t;
  typedef struct {
    logic [1:0]  am;
    logic [1:0]  wm;
    logic [AW:0] len;
    int          pat;
    int          exp_beats;
    int          exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_commit = 1'b0;
  logic        start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  line_t       a_in = '0;
  line_t       w_in = '0;
  logic [AW:0] len = '0;
  logic [1:0]  a_mode = 2'b00;
  logic [1:0]  w_mode = 2'b00;
  logic        fill_ready, start_err, busy, done;
`ifdef STREAM_DISPATCHER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  bank_t bank_q[$];
  beat_t sb_q[$];
  vec_t  vecs[7];

  stream_dispatcher_if #(.DATA_W(DATA_W)) strm_if ();

  stream_dispatcher #(
    .DATA_W  (DATA_W),
    .GROUP_W (GROUP_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .w_in       (w_in),
    .a_in       (a_in),
    .wr_commit  (wr_commit),
    .fill_ready (fill_ready),
    .start      (start),
    .len        (len),
    .a_mode     (a_mode),
    .w_mode     (w_mode),
    .start_err  (start_err),
    .busy       (busy),
    .strm       (strm_if),
    .done       (done)
`ifdef STREAM_DISPATCHER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input line_t act, input line_t exp);
    int g;
    checks++;
    if (act !== exp) begin
      errors++;
      g = 0;
      for (int k = 0; k < DATA_W / GROUP_W; k++) begin
        if (act[k*GROUP_W +: GROUP_W] !== exp[k*GROUP_W +: GROUP_W]) begin
          g = k;
          break;
        end
      end
      $display("FAIL %s: group %0d got %h expected %h", name, g,
               act[g*GROUP_W +: GROUP_W], exp[g*GROUP_W +: GROUP_W]);
    end
  endtask

  // Reference expansion written directly from the mode definitions.
  function automatic line_t ref_expand(input line_t l, input logic [1:0] m);
    line_t r;
    case (m)
      2'b00:   r = l;
      2'b01:   r = {{4{l[255:192]}}, {4{l[191:128]}}, {4{l[127:64]}}, {4{l[63:0]}}};
      2'b10:   r = {4{l[255:0]}};
      default: r = {16{l[63:0]}};
    endcase
    return r;
  endfunction

  // pat 0: addr*0x1111 words; pat 1: group k = k+1 tagged with addr;
  // pat 2: random; pat 3: random with 0xDEADBEEF_01234567 in activation g0.
  function automatic line_t make_line(input int pat, input int addr, input bit is_w);
    line_t l;
    logic [15:0] v;
    l = '0;
    if (pat == 0) begin
      v = 16'(addr) * 16'h1111 + (is_w ? 16'h0101 : 16'h0000);
      for (int j = 0; j < DATA_W / 16; j++) l[j*16 +: 16] = v;
    end else if (pat == 1) begin
      for (int k = 0; k < 16; k++)
        l[k*64 +: 64] = 64'(k + 1) | (64'(addr) << 32) | (is_w ? 64'h100 : 64'h0);
    end else begin
      for (int j = 0; j < DATA_W / 32; j++) l[j*32 +: 32] = $urandom;
      if (pat == 3 && !is_w) l[63:0] = 64'hDEADBEEF_01234567;
    end
    return l;
  endfunction

  task automatic fill_bank(input int pat, input bit expect_ok);
    bank_t b;
    chk("fill_ready_before_fill", 32'(fill_ready), 32'(expect_ok));
    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      a_in    = make_line(pat, a, 1'b0);
      w_in    = make_line(pat, a, 1'b1);
      b.a[a]  = a_in;
      b.w[a]  = w_in;
      tick();
    end
    wr_en     = 1'b0;
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    if (expect_ok) bank_q.push_back(b);
  endtask

  task automatic start_stream(input logic [1:0] am, input logic [1:0] wm, input logic [AW:0] l);
    bank_t b;
    beat_t e;
    int eff;
    eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
    b = bank_q.pop_front();
    for (int i = 0; i < eff; i++) begin
      e.act  = ref_expand(b.a[i], am);
      e.wgt  = ref_expand(b.w[i], wm);
      e.last = (i == eff - 1);
      sb_q.push_back(e);
    end
    beats_seen = 0;
    a_mode = am;
    w_mode = wm;
    len    = l;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // exp_done counts edges after the start edge until done is visible
  // (done sampled at T+2+eff_len means visible after edge T+1+eff_len).
  task automatic wait_done(input string name, input int exp_beats, input int exp_done, input bit chk_timing);
    int lat;
    logic v1;
    lat = 0;
    v1  = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 1) v1 = strm_if.out_valid;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(lat != 0), 32'd1);
    if (chk_timing) begin
      chk({name, "_done_latency"}, 32'(lat), 32'(exp_done));
      chk({name, "_first_valid"}, 32'(v1), 32'(exp_beats > 0));
    end
    chk({name, "_beats"}, 32'(beats_seen), 32'(exp_beats));
    chk({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    tick();
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_idle_after_done"}, 32'(busy), 32'd0);
    $display("stream %s: beats=%0d done_after=%0d cycles", name, beats_seen, lat);
  endtask

  // Output monitor: checks accepted beats against the queue and that a
  // stalled beat stays unchanged.
  initial begin
    beat_t e;
    bit    prev_stall;
    line_t held_a, held_w;
    prev_stall = 1'b0;
    held_a = '0;
    held_w = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(strm_if.out_valid), 32'd1);
          chk_line("hold_act", strm_if.activations, held_a);
          chk_line("hold_wgt", strm_if.weight_columns, held_w);
        end
        if (strm_if.out_valid && strm_if.out_ready) begin
          beats_seen++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat %0d expected none", beats_seen);
          end else begin
            e = sb_q.pop_front();
            chk_line("beat_act", strm_if.activations, e.act);
            chk_line("beat_wgt", strm_if.weight_columns, e.wgt);
            chk("beat_last", 32'(strm_if.out_last), 32'(e.last));
            $display("beat %0d act[63:0]=%h wgt[63:0]=%h last=%0b", beats_seen,
                     strm_if.activations[63:0], strm_if.weight_columns[63:0], strm_if.out_last);
          end
        end
        prev_stall = strm_if.out_valid && !strm_if.out_ready;
        held_a = strm_if.activations;
        held_w = strm_if.weight_columns;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{am: 2'b00, wm: 2'b00, len: 3'd4, pat: 0, exp_beats: 4, exp_done: 5};
    vecs[1] = '{am: 2'b11, wm: 2'b11, len: 3'd4, pat: 3, exp_beats: 4, exp_done: 5};
    vecs[2] = '{am: 2'b01, wm: 2'b01, len: 3'd3, pat: 1, exp_beats: 3, exp_done: 4};
    vecs[3] = '{am: 2'b10, wm: 2'b01, len: 3'd2, pat: 2, exp_beats: 2, exp_done: 3};
    vecs[4] = '{am: 2'b00, wm: 2'b11, len: 3'd0, pat: 3, exp_beats: 0, exp_done: 1};
    vecs[5] = '{am: 2'b11, wm: 2'b00, len: 3'd7, pat: 2, exp_beats: 4, exp_done: 5};
    vecs[6] = '{am: 2'b01, wm: 2'b10, len: 3'd1, pat: 1, exp_beats: 1, exp_done: 2};

    strm_if.out_ready = 1'b1;
    tick();
    tick();
    chk("reset_fill_ready", 32'(fill_ready), 32'd1);
    chk("reset_out_valid", 32'(strm_if.out_valid), 32'd0);
    rstn = 1'b1;
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_start_err", 32'(start_err), 32'd0);
    chk("reset_out_last", 32'(strm_if.out_last), 32'd0);
    chk_line("reset_activations", strm_if.activations, '0);
`ifdef STREAM_DISPATCHER_STALL_CNT_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
`endif

    // Start with nothing committed.
    len   = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_err", 32'(start_err), 32'd1);
    chk("empty_start_busy", 32'(busy), 32'd0);
    tick();
    chk("empty_start_err_pulse", 32'(start_err), 32'd0);
    $display("start with no committed bank: start_err pulse observed=%0b", errors == 0);

    // Table-driven streams, out_ready held high.
    for (int i = 0; i < 7; i++) begin
      fill_bank(vecs[i].pat, 1'b1);
      start_stream(vecs[i].am, vecs[i].wm, vecs[i].len);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_beats, vecs[i].exp_done, 1'b1);
    end

    // Ping-pong: fill B while A streams (stalled), then both banks full.
    strm_if.out_ready = 1'b0;
    fill_bank(2, 1'b1);
    start_stream(2'b00, 2'b01, 3'd4);
    fill_bank(0, 1'b1);
    chk("pp_both_full", 32'(fill_ready), 32'd0);
    wr_en     = 1'b1;
    wr_addr   = 2'd2;
    a_in      = '1;
    w_in      = '1;
    wr_commit = 1'b1;
    tick();
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    chk("pp_third_commit_ignored", 32'(fill_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pp_start_busy_no_err", 32'(start_err), 32'd0);
    chk("pp_still_busy", 32'(busy), 32'd1);
    strm_if.out_ready = 1'b1;
    wait_done("pingpong_A", 4, 0, 1'b0);
    chk("pp_fill_ready_after_release", 32'(fill_ready), 32'd1);
    start_stream(2'b11, 2'b10, 3'd4);
    wait_done("pingpong_B", 4, 5, 1'b1);

    // Backpressure: ready per valid cycle 1,0,0,1.
    fill_bank(1, 1'b1);
    start_stream(2'b01, 2'b10, 3'd4);
    tick();
    tick();
    strm_if.out_ready = 1'b0;
    tick();
    tick();
    strm_if.out_ready = 1'b1;
    wait_done("backpressure", 4, 0, 1'b0);
`ifdef STREAM_DISPATCHER_STALL_CNT_EN
    chk("stall_cnt_after_pair", stall_cnt, 32'd2);
`endif

    // Reset during the second beat with both banks committed.
    fill_bank(2, 1'b1);
    fill_bank(3, 1'b1);
    chk("rst_both_full", 32'(fill_ready), 32'd0);
    start_stream(2'b00, 2'b00, 3'd4);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(strm_if.out_valid), 32'd0);
    chk("rst_fill_ready", 32'(fill_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_last", 32'(strm_if.out_last), 32'd0);
    sb_q.delete();
    bank_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_then_start_err", 32'(start_err), 32'd1);
    chk("rst_then_busy", 32'(busy), 32'd0);
    $display("reset mid-stream: banks emptied, start_err=%0b", start_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
